// File: rtl/riscv_pkg.sv
// riscv_pkg: shared constants and types for the RV32I instruction encoder.
//   - opcode constants for the supported instruction classes
//   - canonical NOP (addi x0,x0,0)
//   - kind_t : request class carried on in_kind
//   - enc_state_t : loader state machine states
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_IALU   = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    KIND_LW     = 3'd0,
    KIND_SW     = 3'd1,
    KIND_RTYPE  = 3'd2,
    KIND_BRANCH = 3'd3,
    KIND_IALU   = 3'd4,
    KIND_JAL    = 3'd5,
    KIND_ILL6   = 3'd6,
    KIND_ILL7   = 3'd7
  } kind_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } enc_state_t;

endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational RV32I field packer and immediate range checker.
// Ports:
//   kind            in  3  : request class (kind_t encoding)
//   rd, rs1, rs2    in  5  : register fields
//   funct3          in  3  : funct3 field
//   f7b5            in  1  : funct7 bit 5 (R-type only)
//   imm             in  21 : signed immediate (byte offset for branch/jal)
//   word            out 32 : packed instruction (NOP for illegal kinds)
//   bad_kind        out 1  : kind is not one of the six supported classes
//   bad_imm         out 1  : imm does not fit the class's immediate field
module instr_pack
  import riscv_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic        f7b5,
  input  logic [20:0] imm,
  output logic [31:0] word,
  output logic        bad_kind,
  output logic        bad_imm
);

  // A 12-bit signed field is only exact when every bit above it matches
  // its sign bit; same idea for the 13-bit branch offset.
  logic fits12;
  logic fits13;

  assign fits12 = (imm[20:11] == 10'h000) || (imm[20:11] == 10'h3FF);
  assign fits13 = (imm[20:12] == 9'h000)  || (imm[20:12] == 9'h1FF);

  // NOTE: every output gets a default before the case so no path leaves it
  // unassigned; otherwise synthesis infers a latch.
  always_comb begin
    word     = NOP;
    bad_kind = 1'b0;
    bad_imm  = 1'b0;
    case (kind_t'(kind))
      KIND_LW: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_LOAD};
        bad_imm = !fits12;
      end
      KIND_IALU: begin
        word    = {imm[11:0], rs1, funct3, rd, OP_IALU};
        bad_imm = !fits12;
      end
      KIND_SW: begin
        word    = {imm[11:5], rs2, rs1, funct3, imm[4:0], OP_STORE};
        bad_imm = !fits12;
      end
      KIND_RTYPE: begin
        word = {1'b0, f7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RTYPE};
      end
      KIND_BRANCH: begin
        word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BRANCH};
        bad_imm = !fits13 || imm[0];
      end
      KIND_JAL: begin
        word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        bad_imm = imm[0];
      end
      default: begin
        word     = NOP;
        bad_kind = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: sequential RV32I encoder and instruction-memory loader.
// A session starts in IDLE on `start`, accepts `count` field-level requests
// over a valid/ready channel, and writes each packed word to consecutive
// word addresses starting at `base` (low two bits forced to zero).
// Ports:
//   clk, reset                : clock, asynchronous active-high reset
//   start, base, count        : session request (sampled in IDLE only)
//   in_valid / in_ready       : request handshake
//   in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_f7b5, in_imm : fields
//   imem_we, imem_addr, imem_wdata : registered memory write port
//   busy                      : state != IDLE
//   done                      : one-cycle pulse in the DRAIN cycle
//   err_kind, err_imm         : sticky errors, cleared by an accepted start
module instr_encoder
  import riscv_pkg::*;
#(
  parameter int AW = 32,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] base,
  input  logic [CW-1:0] count,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [2:0]    in_kind,
  input  logic [4:0]    in_rd,
  input  logic [4:0]    in_rs1,
  input  logic [4:0]    in_rs2,
  input  logic [2:0]    in_funct3,
  input  logic          in_f7b5,
  input  logic [20:0]   in_imm,
  output logic          imem_we,
  output logic [AW-1:0] imem_addr,
  output logic [31:0]   imem_wdata,
  output logic          busy,
  output logic          done,
  output logic          err_kind,
  output logic          err_imm
);

  enc_state_t    state;
  logic [CW-1:0] rem;
  logic [AW-1:0] addr;

  logic [31:0] pack_word;
  logic        pack_bad_kind;
  logic        pack_bad_imm;
  logic        xfer;

  instr_pack u_pack (
    .kind     (in_kind),
    .rd       (in_rd),
    .rs1      (in_rs1),
    .rs2      (in_rs2),
    .funct3   (in_funct3),
    .f7b5     (in_f7b5),
    .imm      (in_imm),
    .word     (pack_word),
    .bad_kind (pack_bad_kind),
    .bad_imm  (pack_bad_imm)
  );

  // Both decode straight from the state register, so in_ready falls in the
  // cycle after the last transfer with no extra flop.
  assign in_ready = (state == RUN);
  assign busy     = (state != IDLE);
  assign xfer     = in_valid && in_ready;

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      rem        <= '0;
      addr       <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      done       <= 1'b0;
      err_kind   <= 1'b0;
      err_imm    <= 1'b0;
    end else begin
      // Strobes are single-cycle unless re-asserted below.
      imem_we <= 1'b0;
      done    <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            addr     <= base & ~AW'(3);
            rem      <= count;
            err_kind <= 1'b0;
            err_imm  <= 1'b0;
            if (count == '0) begin
              // Empty session: go straight to DRAIN so done still pulses.
              state <= DRAIN;
              done  <= 1'b1;
            end else begin
              state <= RUN;
            end
          end
        end
        RUN: begin
          if (xfer) begin
            imem_we    <= 1'b1;
            imem_addr  <= addr;
            imem_wdata <= pack_word;
            addr       <= addr + AW'(4);
            rem        <= rem - CW'(1);
            if (pack_bad_kind) err_kind <= 1'b1;
            if (pack_bad_imm)  err_imm  <= 1'b1;
            if (rem == CW'(1)) begin
              // done lines up with the final write, which lands in DRAIN.
              state <= DRAIN;
              done  <= 1'b1;
            end
          end
        end
        DRAIN: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// tb_instr_encoder: directed self-checking bench for instr_encoder.
module tb_instr_encoder;
  import riscv_pkg::*;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] base;
  logic [15:0] count;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [4:0]  in_rd;
  logic [4:0]  in_rs1;
  logic [4:0]  in_rs2;
  logic [2:0]  in_funct3;
  logic        in_f7b5;
  logic [20:0] in_imm;
  logic        imem_we;
  logic [31:0] imem_addr;
  logic [31:0] imem_wdata;
  logic        busy;
  logic        done;
  logic        err_kind;
  logic        err_imm;

  int checks   = 0;
  int failures = 0;

  instr_encoder #(.AW(32), .CW(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .base       (base),
    .count      (count),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_kind    (in_kind),
    .in_rd      (in_rd),
    .in_rs1     (in_rs1),
    .in_rs2     (in_rs2),
    .in_funct3  (in_funct3),
    .in_f7b5    (in_f7b5),
    .in_imm     (in_imm),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .busy       (busy),
    .done       (done),
    .err_kind   (err_kind),
    .err_imm    (err_imm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then observed and inputs changed 1ns
  // after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [2:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                     input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                     input logic [20:0] imm);
    in_valid  = 1'b1;
    in_kind   = k;
    in_rd     = rd;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_funct3 = f3;
    in_f7b5   = f7;
    in_imm    = imm;
  endtask

  task automatic begin_session(input logic [31:0] b, input logic [15:0] n);
    start = 1'b1;
    base  = b;
    count = n;
    tick();
    start = 1'b0;
  endtask

  task automatic check_write(input string tag, input logic [31:0] a, input logic [31:0] d);
    check({tag, "_we"},   {31'd0, imem_we}, 32'd1);
    check({tag, "_addr"}, imem_addr, a);
    check({tag, "_data"}, imem_wdata, d);
  endtask

  initial begin
    logic        v;
    logic        x;
    int          n_sent;
    int          n_written;
    logic [31:0] exp_d;

    reset    = 1'b1;
    start    = 1'b0;
    base     = '0;
    count    = '0;
    in_valid = 1'b0;
    in_kind  = '0;
    in_rd    = '0;
    in_rs1   = '0;
    in_rs2   = '0;
    in_funct3 = '0;
    in_f7b5  = 1'b0;
    in_imm   = '0;
    tick();
    tick();

    // Reset values
    check("rst_ready", {31'd0, in_ready}, 32'd0);
    check("rst_we",    {31'd0, imem_we}, 32'd0);
    check("rst_addr",  imem_addr, 32'd0);
    check("rst_wdata", imem_wdata, 32'd0);
    check("rst_busy",  {31'd0, busy}, 32'd0);
    check("rst_done",  {31'd0, done}, 32'd0);
    check("rst_errs",  {30'd0, err_kind, err_imm}, 32'd0);
    reset = 1'b0;
    tick();

    // Session 1: three back-to-back requests; start during RUN is ignored
    begin_session(32'h0000_0100, 16'd3);
    check("s1_busy",  {31'd0, busy}, 32'd1);
    check("s1_ready", {31'd0, in_ready}, 32'd1);
    req(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd5);          // addi x1,x0,5
    tick();
    check_write("s1_w0", 32'h0000_0100, 32'h0050_0093);
    check("s1_w0_done", {31'd0, done}, 32'd0);
    req(KIND_RTYPE, 5'd2, 5'd1, 5'd1, 3'd0, 1'b0, 21'd0);         // add x2,x1,x1
    start = 1'b1; base = 32'h0000_0900; count = 16'd0;
    tick();
    start = 1'b0;
    check_write("s1_w1", 32'h0000_0104, 32'h0010_8133);
    check("s1_w1_done", {31'd0, done}, 32'd0);
    req(KIND_SW, 5'd0, 5'd0, 5'd2, 3'd2, 1'b0, 21'd8);            // sw x2,8(x0)
    tick();
    in_valid = 1'b0;
    check_write("s1_w2", 32'h0000_0108, 32'h0020_2423);
    check("s1_w2_done",  {31'd0, done}, 32'd1);
    check("s1_w2_ready", {31'd0, in_ready}, 32'd0);
    tick();
    check("s1_end_we",   {31'd0, imem_we}, 32'd0);
    check("s1_end_done", {31'd0, done}, 32'd0);
    check("s1_end_busy", {31'd0, busy}, 32'd0);

    // Session 2: branch, jal, lw, sub
    begin_session(32'h0000_0300, 16'd4);
    req(KIND_BRANCH, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 21'h1F_FFFC); // beq x1,x2,-4
    tick();
    check_write("s2_beq", 32'h0000_0300, 32'hFE20_8EE3);
    req(KIND_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048);       // jal x1,2048
    tick();
    check_write("s2_jal", 32'h0000_0304, 32'h0010_00EF);
    req(KIND_LW, 5'd5, 5'd6, 5'd0, 3'd2, 1'b0, 21'h1F_FFF8);     // lw x5,-8(x6)
    tick();
    check_write("s2_lw", 32'h0000_0308, 32'hFF83_2283);
    req(KIND_RTYPE, 5'd3, 5'd4, 5'd5, 3'd0, 1'b1, 21'd0);         // sub x3,x4,x5
    tick();
    in_valid = 1'b0;
    check_write("s2_sub", 32'h0000_030C, 32'h4052_01B3);
    check("s2_errs", {30'd0, err_kind, err_imm}, 32'd0);
    tick();

    // Session 3: out-of-range imm and illegal kind, then flags clear
    begin_session(32'h0000_0600, 16'd2);
    req(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2048);
    tick();
    check_write("s3_bigimm", 32'h0000_0600, 32'h8000_0093);
    check("s3_err_imm_set", {31'd0, err_imm}, 32'd1);
    check("s3_err_kind_clr", {31'd0, err_kind}, 32'd0);
    req(3'd7, 5'd9, 5'd9, 5'd9, 3'd7, 1'b1, 21'd1);
    tick();
    in_valid = 1'b0;
    check_write("s3_ill", 32'h0000_0604, 32'h0000_0013);
    check("s3_err_kind_set", {31'd0, err_kind}, 32'd1);
    tick();
    check("s3_hold", {30'd0, err_kind, err_imm}, 32'd3);

    // Zero-count session: done once, no write, errors cleared
    begin_session(32'h0000_0700, 16'd0);
    check("z_done1", {31'd0, done}, 32'd1);
    check("z_we1",   {31'd0, imem_we}, 32'd0);
    check("z_errs",  {30'd0, err_kind, err_imm}, 32'd0);
    tick();
    check("z_done2", {31'd0, done}, 32'd0);
    check("z_we2",   {31'd0, imem_we}, 32'd0);
    check("z_busy2", {31'd0, busy}, 32'd0);
    tick();
    check("z_done3", {31'd0, done}, 32'd0);

    // Random in_valid gaps: addresses stay contiguous, bounded run
    begin_session(32'h0000_0200, 16'd4);
    n_sent = 0;
    n_written = 0;
    for (int cyc = 0; cyc < 80 && n_written < 4; cyc++) begin
      v = (n_sent < 4) && ($urandom_range(0, 1) == 1);
      req(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'(n_sent));
      in_valid = v;
      x = v && in_ready;
      exp_d = (32'(n_sent) << 20) | 32'h0000_0093;
      tick();
      check("gap_we", {31'd0, imem_we}, {31'd0, x});
      if (x) begin
        check("gap_addr", imem_addr, 32'h0000_0200 + 32'(4 * n_written));
        check("gap_data", imem_wdata, exp_d);
        n_sent++;
        n_written++;
      end
    end
    in_valid = 1'b0;
    check("gap_count", 32'(n_written), 32'd4);
    tick();

    // Address wrap; base low bits are ignored
    begin_session(32'hFFFF_FFFF, 16'd2);
    req(KIND_IALU, 5'd2, 5'd0, 5'd0, 3'd0, 1'b0, 21'd1);
    tick();
    check_write("wrap0", 32'hFFFF_FFFC, 32'h0010_0113);
    req(KIND_IALU, 5'd3, 5'd0, 5'd0, 3'd0, 1'b0, 21'd2);
    tick();
    in_valid = 1'b0;
    check_write("wrap1", 32'h0000_0000, 32'h0020_0193);
    tick();

    // Reset the cycle after a transfer
    begin_session(32'h0000_0400, 16'd2);
    req(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd3);
    tick();
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
    check("mr_we",    {31'd0, imem_we}, 32'd0);
    check("mr_addr",  imem_addr, 32'd0);
    check("mr_wdata", imem_wdata, 32'd0);
    check("mr_busy",  {31'd0, busy}, 32'd0);
    check("mr_ready", {31'd0, in_ready}, 32'd0);
    check("mr_done",  {31'd0, done}, 32'd0);
    tick();
    reset = 1'b0;
    tick();
    check("mr_idle_we", {31'd0, imem_we}, 32'd0);
    begin_session(32'h0000_0500, 16'd1);
    req(KIND_IALU, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 21'd7);
    tick();
    in_valid = 1'b0;
    check_write("mr_next", 32'h0000_0500, 32'h0070_0093);
    check("mr_next_done", {31'd0, done}, 32'd1);
    tick();
    check("mr_next_busy", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
# instr_encoder

Sequential RISC-V instruction encoder and instruction-memory loader, the inverse of the main decoder. It accepts a stream of field-level instruction requests (class, registers, funct3, immediate) over a valid/ready channel. Each request is packed into a 32-bit RV32I word and written to the instruction memory write port at consecutive word addresses. Bench code and boot logic use it to build programs for the pipelined core without hand-assembled hex.

## Interface
Parameters:
- `AW`, default 32: instruction-memory byte-address width.
- `CW`, default 16: instruction-count width.

Ports:
- `clk`  in  1: single clock; all state on rising edge.
- `reset`  in  1: asynchronous, active-high.
- `start`  in  1: begin a load session; sampled only in IDLE.
- `base`  in  AW: first byte address; bits [1:0] ignored (forced 0).
- `count`  in  CW: number of instructions in the session.
- `in_valid`  in  1: request valid.
- `in_ready`  out  1: encoder can accept.
- `in_kind`  in  3: 0 lw, 1 sw, 2 R-type, 3 branch, 4 I-ALU, 5 jal, 6/7 illegal.
- `in_rd`, `in_rs1`, `in_rs2`  in  5 each: register fields.
- `in_funct3`  in  3: funct3.
- `in_f7b5`  in  1: funct7 bit 5 (R-type only).
- `in_imm`  in  21: signed immediate, byte offset for branch/jal.
- `imem_we`  out  1: write strobe.
- `imem_addr`  out  AW: byte address.
- `imem_wdata`  out  32: encoded instruction.
- `busy`  out  1: state != IDLE.
- `done`  out  1: one-cycle pulse at session end.
- `err_kind`, `err_imm`  out  1 each: sticky error flags.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE -> RUN on `start` with `count`>0. This loads `rem`=count and `addr`=base & ~3, and clears both error flags.
- IDLE -> DRAIN on `start` with `count`==0. No writes occur; `done` pulses next cycle.
- `start` is ignored outside IDLE.
- `in_ready` = (state==RUN). A transfer is `in_valid & in_ready`.
- Each transfer decrements `rem`. The transfer at `rem`==1 moves RUN -> DRAIN.
- DRAIN -> IDLE unconditionally after one cycle.
- Encodings (opcode in bits [6:0]):
  - lw: {imm[11:0], rs1, f3, rd, 0000011}
  - I-ALU: {imm[11:0], rs1, f3, rd, 0010011}
  - sw: {imm[11:5], rs2, rs1, f3, imm[4:0], 0100011}
  - R-type: {0, f7b5, 00000, rs2, rs1, f3, rd, 0110011}
  - branch: {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], 1100011}
  - jal: {imm[20], imm[10:1], imm[11], imm[19:12], rd, 1101111}
- Range checks; a failure sets `err_imm`, and the word is still written with the truncated field:
  - lw/sw/I-ALU: imm[20:11] must all be equal.
  - branch: imm[20:12] must all be equal and imm[0]==0.
  - jal: imm[0]==0.
  - R-type: imm is ignored.
- Kind 6/7: write NOP 0x00000013 and set `err_kind`.
- After each write, `addr` += 4, wrapping modulo 2^AW.

## Timing
- Reset values: state IDLE, `in_ready`=0, `imem_we`=0, `imem_addr`=0, `imem_wdata`=0, `busy`=0, `done`=0, both error flags 0.
- Latency is 1 cycle. A transfer in cycle t gives `imem_we`=1 in cycle t+1 with registered addr/data.
- Throughput is 1 instruction per cycle with no bubbles.
- `done` asserts in the DRAIN cycle, coincident with the last `imem_we`. For a zero-count session, `done` asserts with no write.
- `in_ready` drops in the cycle after the last transfer. The pending write still completes in DRAIN.
- Reset mid-session: the state machine returns to IDLE immediately; the pending write is dropped and `imem_we` deasserts asynchronously.
- Error flags hold until the next accepted `start` or reset.

## Structure
- Package `riscv_pkg` holds:
  - opcode constants (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_IALU, OP_JAL);
  - NOP constant 32'h00000013;
  - `kind_t` enum for `in_kind`;
  - `enc_state_t` enum {IDLE, RUN, DRAIN}.
- Sub-module `instr_pack`: purely combinational field packer plus range checker, with outputs word, bad_kind, bad_imm. The top level holds the FSM, counters and output registers.

## Test plan
- Session base=0x100, count=3 with addi x1,x0,5 / add x2,x1,x1 / sw x2,8(x0), all back-to-back -> writes 0x00500093 @0x100, 0x00108133 @0x104, 0x00202423 @0x108, one per cycle. `done` is asserted with the third write.
- Branch beq x1,x2,-4 and jal x1,2048 -> 0xFE208EE3 and 0x001000EF.
- imm=2048 on I-ALU -> `err_imm`=1 and the word is written with imm[11:0]=0x800. kind=7 -> 0x00000013 is written and `err_kind`=1. Both flags clear on the next `start`.
- count=0 -> no `imem_we`; `done` pulses exactly once, one cycle after `start`. `start` pulsed during RUN has no effect.
- Random `in_valid` gaps -> addresses remain contiguous. base=0xFFFFFFFC, count=2 -> writes to 0xFFFFFFFC then 0x00000000.
- Reset asserted the cycle after a transfer -> no write occurs, all outputs return to reset values, and the next session behaves normally.
